// File: rtl/row_bound_finder_32bit_if.sv
// Level-trigger handshake between the row bound finder and the 32-bit mask generator.
// The finder is the master: it raises a request and waits for the generator's done level.
interface row_bound_finder_32bit_if;
    logic        o_mg_trig;
    logic        o_mg_left_or_right;
    logic [4:0]  o_mg_bound_index;
    logic        i_mg_done;
    logic [31:0] i_mg_mask;

    modport master (
        output o_mg_trig,
        output o_mg_left_or_right,
        output o_mg_bound_index,
        input  i_mg_done,
        input  i_mg_mask
    );

    modport slave (
        input  o_mg_trig,
        input  o_mg_left_or_right,
        input  o_mg_bound_index,
        output i_mg_done,
        output i_mg_mask
    );
endinterface

// File: rtl/row_bound_finder_32bit.sv
// Finds left/right foreground bounds of a 32-bit pixel row by 5-step binary search,
// then fetches the left and right masks from the mask generator with a per-edge watchdog.
module row_bound_finder_32bit #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trig,
    input  logic [31:0] i_row,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_valid,
    output logic        o_err,
    output logic [4:0]  o_left_index,
    output logic [4:0]  o_right_index,
    output logic [31:0] o_left_mask,
    output logic [31:0] o_right_mask,
    row_bound_finder_32bit_if.master mg
);

    localparam int unsigned ROW_W  = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned WD_W   = 8;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(4);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_CHECK,
        ST_REQ_L,
        ST_REL_L,
        ST_REQ_R,
        ST_REL_R,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [ROW_W-1:0]   lwin_q, lwin_d;
    logic [ROW_W-1:0]   rwin_q, rwin_d;
    logic [IDX_W-1:0]   lcnt_q, lcnt_d;
    logic [IDX_W-1:0]   rcnt_q, rcnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   lidx_q, lidx_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic [ROW_W-1:0]   lmask_q, lmask_d;
    logic [ROW_W-1:0]   rmask_q, rmask_d;
    logic               trig_q, trig_d;
    logic               lr_q, lr_d;
    logic [IDX_W-1:0]   bidx_q, bidx_d;

    // Search width halves each step: 16, 8, 4, 2, 1.
    logic [IDX_W-1:0]   w;
    logic [ROW_W-1:0]   hi_mask;
    logic [ROW_W-1:0]   lo_mask;
    logic               wd_expired;

    assign w          = 5'd16 >> step_q;
    assign hi_mask    = ~({ROW_W{1'b1}} >> w);
    assign lo_mask    = ~({ROW_W{1'b1}} << w);
    assign wd_expired = (wd_q == WD_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lwin_d  = lwin_q;
        rwin_d  = rwin_q;
        lcnt_d  = lcnt_q;
        rcnt_d  = rcnt_q;
        wd_d    = wd_q;
        valid_d = valid_q;
        err_d   = err_q;
        lidx_d  = lidx_q;
        ridx_d  = ridx_q;
        lmask_d = lmask_q;
        rmask_d = rmask_q;
        lr_d    = lr_q;
        bidx_d  = bidx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        trig_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_trig) begin
                    lwin_d  = i_row;
                    rwin_d  = i_row;
                    lcnt_d  = '0;
                    rcnt_d  = '0;
                    step_d  = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    lidx_d  = '0;
                    ridx_d  = '0;
                    lmask_d = '0;
                    rmask_d = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if ((lwin_q & hi_mask) == '0) begin
                    lcnt_d = lcnt_q + w;
                    lwin_d = lwin_q << w;
                end
                if ((rwin_q & lo_mask) == '0) begin
                    rcnt_d = rcnt_q + w;
                    rwin_d = rwin_q >> w;
                end
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // After the search a non-empty row always has its first set bit in lwin[31].
                if (!lwin_q[ROW_W-1]) begin
                    state_d = ST_DONE;
                end else begin
                    valid_d = 1'b1;
                    lidx_d  = lcnt_q;
                    ridx_d  = rcnt_q;
                    lr_d    = 1'b0;
                    bidx_d  = lcnt_q;
                    wd_d    = '0;
                    state_d = ST_REQ_L;
                end
            end
            ST_REQ_L: begin
                if (mg.i_mg_done) begin
                    lmask_d = mg.i_mg_mask;
                    wd_d    = '0;
                    state_d = ST_REL_L;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    lmask_d = '0;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_REL_L: begin
                if (!mg.i_mg_done) begin
                    lr_d    = 1'b1;
                    bidx_d  = rcnt_q;
                    wd_d    = '0;
                    state_d = ST_REQ_R;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    lmask_d = '0;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_REQ_R: begin
                if (mg.i_mg_done) begin
                    rmask_d = mg.i_mg_mask;
                    wd_d    = '0;
                    state_d = ST_REL_R;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    rmask_d = '0;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_REL_R: begin
                if (!mg.i_mg_done) begin
                    state_d = ST_DONE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    rmask_d = '0;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        trig_d = (state_d == ST_REQ_L) || (state_d == ST_REQ_R);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            lwin_q  <= '0;
            rwin_q  <= '0;
            lcnt_q  <= '0;
            rcnt_q  <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lidx_q  <= '0;
            ridx_q  <= '0;
            lmask_q <= '0;
            rmask_q <= '0;
            trig_q  <= 1'b0;
            lr_q    <= 1'b0;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            lwin_q  <= lwin_d;
            rwin_q  <= rwin_d;
            lcnt_q  <= lcnt_d;
            rcnt_q  <= rcnt_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lidx_q  <= lidx_d;
            ridx_q  <= ridx_d;
            lmask_q <= lmask_d;
            rmask_q <= rmask_d;
            trig_q  <= trig_d;
            lr_q    <= lr_d;
            bidx_q  <= bidx_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_valid       = valid_q;
    assign o_err         = err_q;
    assign o_left_index  = lidx_q;
    assign o_right_index = ridx_q;
    assign o_left_mask   = lmask_q;
    assign o_right_mask  = rmask_q;

    assign mg.o_mg_trig          = trig_q;
    assign mg.o_mg_left_or_right = lr_q;
    assign mg.o_mg_bound_index   = bidx_q;

endmodule
